// File: rtl/pmem_arbiter.sv
// pmem_arbiter: grants the single physical memory port to either the I-cache or the D-cache.
// A grant is held until the memory responds or the granted cache drops its request.
// The response is then forwarded only to the granted cache.
//
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   i_pmem_*              I-cache side (read-only): address, read, rdata, resp
//   d_pmem_*              D-cache side: address, read, write, wdata, rdata, resp
//   pmem_*                physical memory side: address, read, write, wdata, rdata, resp
//
// Optional feature:
//   PMEM_ARB_ROUND_ROBIN_EN  when defined, a tie in idle grants the cache that was not
//                            served last. When undefined, a tie always grants the D-cache.

module pmem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic [ADDR_WIDTH-1:0] i_pmem_address,
  input  logic                  i_pmem_read,
  output logic [LINE_WIDTH-1:0] i_pmem_rdata,
  output logic                  i_pmem_resp,

  input  logic [ADDR_WIDTH-1:0] d_pmem_address,
  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
  output logic [LINE_WIDTH-1:0] d_pmem_rdata,
  output logic                  d_pmem_resp,

  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  typedef enum logic [1:0] {
    StIdle,
    StServeI,
    StServeD
  } state_e;

  localparam logic GrantI = 1'b0;
  localparam logic GrantD = 1'b1;

  state_e state_q, state_d;
  logic   last_grant_q, last_grant_d;
  logic   i_req, d_req, tie_to_d;

  assign i_req = i_pmem_read;
  assign d_req = d_pmem_read | d_pmem_write;

`ifdef PMEM_ARB_ROUND_ROBIN_EN
  assign tie_to_d = (last_grant_q == GrantI);
`else
  // last_grant is still tracked but has no effect in the fixed-priority build.
  logic unused_last_grant;
  assign unused_last_grant = last_grant_q;
  assign tie_to_d = 1'b1;
`endif

  // Data paths are pure passthroughs; each cache qualifies rdata with its own resp.
  assign pmem_wdata   = d_pmem_wdata;
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_grant_q <= GrantI;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      StIdle: begin
        if (i_req && d_req) begin
          state_d = tie_to_d ? StServeD : StServeI;
        end else if (d_req) begin
          state_d = StServeD;
        end else if (i_req) begin
          state_d = StServeI;
        end
      end
      StServeI: begin
        if (pmem_resp) begin
          state_d      = StIdle;
          last_grant_d = GrantI;
        end else if (!i_req) begin
          state_d = StIdle;  // abort: last_grant left as is
        end
      end
      StServeD: begin
        if (pmem_resp) begin
          state_d      = StIdle;
          last_grant_d = GrantD;
        end else if (!d_req) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pmem_address = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    i_pmem_resp  = 1'b0;
    d_pmem_resp  = 1'b0;
    unique case (state_q)
      StServeI: begin
        pmem_address = i_pmem_address;
        pmem_read    = i_pmem_read;
        i_pmem_resp  = pmem_resp;
      end
      StServeD: begin
        pmem_address = d_pmem_address;
        pmem_read    = d_pmem_read;
        pmem_write   = d_pmem_write;
        d_pmem_resp  = pmem_resp;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pmem_arbiter.sv
// Testbench for pmem_arbiter: directed scenarios followed by random traffic, every cycle
// checked against a reference model of the memory-port ownership rules.

module tb_pmem_arbiter;

  localparam int unsigned AW = 16;
  localparam int unsigned LW = 128;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] i_pmem_address, d_pmem_address, pmem_address;
  logic          i_pmem_read, d_pmem_read, d_pmem_write;
  logic [LW-1:0] i_pmem_rdata, d_pmem_rdata, d_pmem_wdata, pmem_wdata, pmem_rdata;
  logic          i_pmem_resp, d_pmem_resp, pmem_read, pmem_write, pmem_resp;

  always #5 clk = ~clk;

  pmem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_pmem_address (i_pmem_address),
    .i_pmem_read    (i_pmem_read),
    .i_pmem_rdata   (i_pmem_rdata),
    .i_pmem_resp    (i_pmem_resp),
    .d_pmem_address (d_pmem_address),
    .d_pmem_read    (d_pmem_read),
    .d_pmem_write   (d_pmem_write),
    .d_pmem_wdata   (d_pmem_wdata),
    .d_pmem_rdata   (d_pmem_rdata),
    .d_pmem_resp    (d_pmem_resp),
    .pmem_address   (pmem_address),
    .pmem_read      (pmem_read),
    .pmem_write     (pmem_write),
    .pmem_wdata     (pmem_wdata),
    .pmem_rdata     (pmem_rdata),
    .pmem_resp      (pmem_resp)
  );

  int vectors = 0;
  int miscompares = 0;
  int i_resp_seen = 0;

  // Reference model: who owns the memory port (0 none, 1 I-cache, 2 D-cache) and who
  // completed most recently (1 I-cache, 2 D-cache).
  int owner = 0;
  int last  = 1;

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [LW-1:0] e_addr;
    logic          e_rd, e_wr, e_ir, e_dr;
    e_addr = '0; e_rd = 1'b0; e_wr = 1'b0; e_ir = 1'b0; e_dr = 1'b0;
    if (owner == 1) begin
      e_addr = LW'(i_pmem_address); e_rd = i_pmem_read; e_ir = pmem_resp;
    end else if (owner == 2) begin
      e_addr = LW'(d_pmem_address); e_rd = d_pmem_read; e_wr = d_pmem_write; e_dr = pmem_resp;
    end
    chk("pmem_address", LW'(pmem_address), e_addr);
    chk("pmem_read",    LW'(pmem_read),    LW'(e_rd));
    chk("pmem_write",   LW'(pmem_write),   LW'(e_wr));
    chk("i_pmem_resp",  LW'(i_pmem_resp),  LW'(e_ir));
    chk("d_pmem_resp",  LW'(d_pmem_resp),  LW'(e_dr));
    chk("pmem_wdata",   pmem_wdata,   d_pmem_wdata);
    chk("i_pmem_rdata", i_pmem_rdata, pmem_rdata);
    chk("d_pmem_rdata", d_pmem_rdata, pmem_rdata);
    if (i_pmem_resp === 1'b1) i_resp_seen++;
  endtask

  task automatic model_edge();
    bit ir, dr;
    ir = (i_pmem_read === 1'b1);
    dr = (d_pmem_read === 1'b1) || (d_pmem_write === 1'b1);
    if (rst_n !== 1'b1) begin
      owner = 0; last = 1;
    end else if (owner == 0) begin
      if (ir && dr) begin
`ifdef PMEM_ARB_ROUND_ROBIN_EN
        owner = (last == 1) ? 2 : 1;
`else
        owner = 2;
`endif
      end else if (dr) owner = 2;
      else if (ir) owner = 1;
    end else if (pmem_resp === 1'b1) begin
      last = owner; owner = 0;
    end else if ((owner == 1 && !ir) || (owner == 2 && !dr)) begin
      owner = 0;
    end
  endtask

  // Inputs change on the falling edge; outputs are checked just after it.
  task automatic step();
    #1 check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic reset_on();
    rst_n = 1'b0; owner = 0; last = 1;
  endtask

  task automatic idle_inputs();
    i_pmem_read = 1'b0; d_pmem_read = 1'b0; d_pmem_write = 1'b0; pmem_resp = 1'b0;
  endtask

  function automatic logic [LW-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [LW-1:0] beef;
    beef = {4{32'hDEADBEEF}};
    @(negedge clk);

    // Reset with random inputs: all strobes, resps and address must be zero.
    reset_on();
    for (int k = 0; k < 3; k++) begin
      i_pmem_address = AW'($urandom); d_pmem_address = AW'($urandom);
      i_pmem_read = 1'($urandom); d_pmem_read = 1'($urandom); d_pmem_write = 1'($urandom);
      pmem_resp = 1'($urandom); d_pmem_wdata = rnd_line(); pmem_rdata = rnd_line();
      step();
    end
    idle_inputs();
    rst_n = 1'b1;
    step();

    // Single I read, memory responds in the third served cycle.
    i_pmem_address = 16'h1230; i_pmem_read = 1'b1; pmem_rdata = rnd_line();
    i_resp_seen = 0;
    step();
    step();
    step();
    pmem_resp = 1'b1; pmem_rdata = beef;
    step();
    i_pmem_read = 1'b0; pmem_resp = 1'b0;
    step();
    chk("i_resp_pulses", LW'(i_resp_seen), LW'(1));

    // D write-back, then refill with an idle cycle in between.
    d_pmem_address = 16'h4560; d_pmem_write = 1'b1; d_pmem_wdata = rnd_line();
    step();
    step();
    pmem_resp = 1'b1;
    step();
    pmem_resp = 1'b0; d_pmem_write = 1'b0; d_pmem_read = 1'b1; d_pmem_address = 16'h7890;
    chk("wb_gap_read", LW'(pmem_read), LW'(0));
    step();
    step();
    pmem_resp = 1'b1; pmem_rdata = rnd_line();
    step();
    idle_inputs();
    step();

    // Simultaneous requests straight from reset, then a second tie.
    reset_on();
    step();
    rst_n = 1'b1;
    i_pmem_address = 16'h0AA0; d_pmem_address = 16'h0BB0;
    i_pmem_read = 1'b1; d_pmem_read = 1'b1;
    step();
    chk("tie1_d_granted", LW'(pmem_address), LW'(16'h0BB0));
    pmem_resp = 1'b1;
    step();
    pmem_resp = 1'b0;
    step();
`ifdef PMEM_ARB_ROUND_ROBIN_EN
    chk("tie2_grant", LW'(pmem_address), LW'(16'h0AA0));
`else
    chk("tie2_grant", LW'(pmem_address), LW'(16'h0BB0));
`endif
    pmem_resp = 1'b1;
    step();
    idle_inputs();
    step();

    // Isolation: D-cache writes toggle while the I-cache is served.
    i_pmem_read = 1'b1; i_pmem_address = 16'h2220;
    step();
    for (int k = 0; k < 4; k++) begin
      d_pmem_write = ~d_pmem_write; d_pmem_wdata = rnd_line();
      chk("iso_write", LW'(pmem_write), LW'(0));
      step();
    end
    pmem_resp = 1'b1;
    step();
    idle_inputs();
    step();

    // Reset during SERVE_D, then memory responds while reset is held.
    d_pmem_read = 1'b1; d_pmem_address = 16'h3330;
    step();
    step();
    reset_on();
    step();
    pmem_resp = 1'b1;
    step();
    rst_n = 1'b1; pmem_resp = 1'b0; d_pmem_read = 1'b0;
    step();
    step();

    // Random traffic with occasional aborts and stray responses.
    for (int k = 0; k < 3000; k++) begin
      i_pmem_address = AW'($urandom); d_pmem_address = AW'($urandom);
      if ($urandom_range(0, 5) == 0) i_pmem_read = ~i_pmem_read;
      if ($urandom_range(0, 5) == 0) begin
        d_pmem_read = 1'($urandom); d_pmem_write = 1'($urandom);
      end
      pmem_resp = ($urandom_range(0, 3) == 0);
      d_pmem_wdata = rnd_line(); pmem_rdata = rnd_line();
      if ($urandom_range(0, 199) == 0) reset_on();
      else rst_n = 1'b1;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
